// File: rtl/lcd_value_formatter.sv
// Formats two unsigned values as right-justified decimal ASCII rows for a 16x2 character LCD.
// Latency: result and done pulse land 2*DATA_W+1 edges after start is accepted (33 at defaults).
// Backpressure: none; start is only honoured in IDLE, and a start while busy is dropped, not queued.
module lcd_value_formatter #(
   parameter int DATA_W   = 16,
   parameter int DIGITS   = 5,
   parameter int LZ_BLANK = 1
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] value_a,
   input  logic [DATA_W-1:0] value_b,
   output logic              busy,
   output logic              done,
   output logic [255:0]      string_out
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(DATA_W + 1);
   // Each 16-char row is "X=" followed by the digits and space padding.
   localparam int PAD   = 14 - DIGITS;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      CONV_A,
      CONV_B,
      ASSEMBLE
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] shift;
   logic [DATA_W-1:0] lat_b;
   logic [BCD_W-1:0]  bcd;
   logic [BCD_W-1:0]  bcd_a;
   logic [CNT_W-1:0]  bit_cnt;
   logic [BCD_W-1:0]  bcd_adj;
   logic [BCD_W-1:0]  bcd_nxt;

   // Double-dabble correction: any nibble of 5 or more gets +3 before the shift.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) begin
            bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
         end
      end
   end

   // The corrected BCD picks up the top bit of the binary shift register.
   assign bcd_nxt = {bcd_adj[BCD_W-2:0], shift[DATA_W-1]};

   // Turns BCD into ASCII digits, MSD in the top byte; leading zeros may become spaces.
   function automatic logic [8*DIGITS-1:0] fmt_digits(input logic [BCD_W-1:0] v);
      logic [8*DIGITS-1:0] r;
      logic                seen;
      logic [3:0]          nib;
      r    = '0;
      seen = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nib = v[i*4 +: 4];
         // The units digit is always shown, so zero renders as "0" not blank.
         if (nib != 4'd0 || i == 0) begin
            seen = 1'b1;
         end
         if (LZ_BLANK != 0 && !seen) begin
            r[i*8 +: 8] = 8'h20;
         end else begin
            r[i*8 +: 8] = 8'h30 + {4'd0, nib};
         end
      end
      return r;
   endfunction

   // One 16-character display row: label, '=', digits, trailing spaces.
   function automatic logic [127:0] make_row(input logic [7:0] label, input logic [BCD_W-1:0] v);
      return {label, 8'h3D, fmt_digits(v), {PAD{8'h20}}};
   endfunction

   // Control FSM with the converter datapath and registered outputs.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         string_out <= {32{8'h20}};
         shift      <= '0;
         lat_b      <= '0;
         bcd        <= '0;
         bcd_a      <= '0;
         bit_cnt    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  shift   <= value_a;
                  lat_b   <= value_b;
                  bcd     <= '0;
                  bit_cnt <= '0;
                  busy    <= 1'b1;
                  state   <= CONV_A;
               end
            end
            CONV_A: begin
               if (bit_cnt == LAST_BIT) begin
                  // A is finished: park its digits and restart the converter on B.
                  bcd_a   <= bcd_nxt;
                  shift   <= lat_b;
                  bcd     <= '0;
                  bit_cnt <= '0;
                  state   <= CONV_B;
               end else begin
                  bcd     <= bcd_nxt;
                  shift   <= {shift[DATA_W-2:0], 1'b0};
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            CONV_B: begin
               bcd     <= bcd_nxt;
               shift   <= {shift[DATA_W-2:0], 1'b0};
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  state <= ASSEMBLE;
               end
            end
            ASSEMBLE: begin
               // The whole string changes in one edge so the LCD never sees a half-updated frame.
               string_out <= {make_row(8'h41, bcd_a), make_row(8'h42, bcd)};
               done       <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_value_formatter.sv
// Directed bench for lcd_value_formatter: one blanking and one zero-padded instance side by side.
// Expected strings come from an arithmetic model and are queued when a start is expected to be accepted.
// Each done pops the queue and checks both strings, done latency and busy duration.
module tb_lcd_value_formatter;

   localparam logic [255:0] SPACES = {32{8'h20}};

   logic         sys_clk;
   logic         rst;
   logic         start;
   logic [15:0]  value_a;
   logic [15:0]  value_b;
   logic         busy0, done0, busy1, done1;
   logic [255:0] str0, str1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int busy_run = 0;
   int done_cnt = 0;

   typedef struct {
      logic [255:0] exp_blank;
      logic [255:0] exp_zero;
      int           k;
   } exp_t;

   exp_t sb[$];

   lcd_value_formatter #(.DATA_W(16), .DIGITS(5), .LZ_BLANK(1)) dut (
      .sys_clk(sys_clk), .rst(rst), .start(start), .value_a(value_a), .value_b(value_b),
      .busy(busy0), .done(done0), .string_out(str0)
   );

   lcd_value_formatter #(.DATA_W(16), .DIGITS(5), .LZ_BLANK(0)) dut_z (
      .sys_clk(sys_clk), .rst(rst), .start(start), .value_a(value_a), .value_b(value_b),
      .busy(busy1), .done(done1), .string_out(str1)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc++;

   task automatic check_vec(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Builds one row by decimal arithmetic: label, '=', five digits, nine spaces.
   function automatic logic [127:0] model_row(input logic [7:0] label, input int v, input bit lz);
      logic [127:0] r;
      int p10;
      int d;
      r = {16{8'h20}};
      r[127:120] = label;
      r[119:112] = 8'h3D;
      p10 = 1;
      for (int i = 0; i < 5; i++) begin
         d = (v / p10) % 10;
         if (lz && i > 0 && v < p10) r[127-8*(6-i) -: 8] = 8'h20;
         else                        r[127-8*(6-i) -: 8] = 8'h30 + d[7:0];
         p10 = p10 * 10;
      end
      return r;
   endfunction

   function automatic logic [255:0] model(input int a, input int b, input bit lz);
      return {model_row(8'h41, a, lz), model_row(8'h42, b, lz)};
   endfunction

   // Drives a one-cycle start from a negedge; queues the expected result if it should be accepted.
   task automatic pulse(input int a, input int b, input bit accept);
      exp_t e;
      value_a = a[15:0];
      value_b = b[15:0];
      start   = 1'b1;
      if (accept) begin
         e.exp_blank = model(a, b, 1'b1);
         e.exp_zero  = model(a, b, 1'b0);
         e.k         = cyc + 1;
         sb.push_back(e);
      end
      @(negedge sys_clk);
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   // Scoreboard consumer: every done must match the oldest queued expectation.
   always @(negedge sys_clk) begin
      exp_t e;
      if (rst) begin
         busy_run = 0;
      end else begin
         if (busy0) busy_run++;
         if (done0) begin
            done_cnt++;
            total++;
            assert (sb.size() != 0) else begin
               bad++;
               $error("FAIL unexpected_done: observed queue size 0 expected nonzero");
            end
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check_vec("str_blank", str0, e.exp_blank);
               check_vec("str_zero", str1, e.exp_zero);
               check_int("latency", cyc - e.k, 33);
               check_int("busy_cycles", busy_run, 33);
               check_int("done_zero_inst", int'(done1), 1);
            end
            busy_run = 0;
         end
      end
   end

   initial begin
      bit got;
      rst     = 1'b1;
      start   = 1'b0;
      value_a = '0;
      value_b = '0;

      // Reset and idle
      idle(3);
      check_vec("reset_str", str0, SPACES);
      check_int("reset_busy", int'(busy0), 0);
      check_int("reset_done", int'(done0), 0);
      rst = 1'b0;
      idle(50);
      check_vec("idle_str", str0, SPACES);
      check_vec("idle_str_z", str1, SPACES);
      check_int("idle_busy", int'(busy0), 0);
      check_int("idle_done_cnt", done_cnt, 0);

      // Basic and boundary conversions
      pulse(12345, 7, 1'b1);
      idle(40);
      check_int("basic_drained", sb.size(), 0);
      pulse(65535, 0, 1'b1);
      idle(40);
      check_int("max_drained", sb.size(), 0);
      pulse(10000, 9999, 1'b1);
      idle(40);
      check_int("pow10_drained", sb.size(), 0);
      pulse(42, 0, 1'b1);
      idle(40);
      check_int("small_drained", sb.size(), 0);
      check_vec("hold_str", str0, model(42, 0, 1'b1));

      // start while busy is dropped
      done_cnt = 0;
      pulse(1, 11, 1'b1);
      idle(9);
      check_int("busy_mid", int'(busy0), 1);
      pulse(2, 22, 1'b0);
      idle(40);
      check_int("ignored_done_cnt", done_cnt, 1);
      check_int("ignored_drained", sb.size(), 0);

      // start in the done cycle is accepted
      pulse(5, 6, 1'b1);
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge sys_clk);
         if (done0) got = 1'b1;
      end
      check_int("done_seen", int'(got), 1);
      pulse(3, 33, 1'b1);
      idle(40);
      check_int("back2back_drained", sb.size(), 0);
      check_vec("back2back_str", str0, model(3, 33, 1'b1));

      // Reset mid-conversion aborts without a done
      done_cnt = 0;
      pulse(555, 1, 1'b1);
      idle(11);
      rst = 1'b1;
      #1;
      check_vec("abort_str", str0, SPACES);
      check_vec("abort_str_z", str1, SPACES);
      check_int("abort_busy", int'(busy0), 0);
      sb.delete();
      idle(2);
      rst = 1'b0;
      idle(40);
      check_int("abort_no_done", done_cnt, 0);
      pulse(8, 123, 1'b1);
      idle(40);
      check_int("after_abort_drained", sb.size(), 0);
      check_vec("after_abort_str", str0, model(8, 123, 1'b1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
